melody_sequencer: RTL
=====================

# melody_sequencer

Playback controller for the keyboard piano tone generator. Steps through a built-in melody ROM and drives the `{degree, key}` note code that the period-select lookup consumes. Arbitrates between autoplay and live PS/2 keystrokes; live keys preempt playback. Sits between the keyboard decoder (`kbpress`, `degree`, one-hot `key`) and the tone-period select / tricolour LED logic.

## Interface
Parameters:
- `BEAT_CYCLES`, 25000000: clock cycles per beat (0.25 s at 100 MHz); must be ≥1.
- `GAP_CYCLES`, 2500000: silent cycles between consecutive notes; must be ≥1.
- `LIVE_CYCLES`, 50000000: hold time of a live keystroke; must be ≥1.
- `SONG_LEN`, 8: number of ROM entries played; range 1..16.

Ports (reset is synchronous, active-high):
- `clk` input, 1 bit: single clock domain (`stdclk`).
- `rst` input, 1 bit: synchronous active-high reset.
- `start` input, 1 bit: one-cycle request to play from entry 0.
- `stop` input, 1 bit: one-cycle request to abort everything.
- `kb_valid` input, 1 bit: keyboard `kbpress` pulse.
- `kb_degree` input, 2 bits: keyboard octave (01 low, 10 mid, 11 high).
- `kb_key` input, 7 bits: one-hot note, bit0=C … bit6=B.
- `degree` output, 2 bits: octave to the period lookup; 00 means silent.
- `key` output, 7 bits: one-hot note; 0 means silent.
- `playing` output, 1 bit: high in NOTE or GAP, and also during LIVE when playback is suspended.
- `live` output, 1 bit: high in LIVE.
- `note_idx` output, 4 bits: current ROM index.
- `done` output, 1 bit: one-cycle pulse when the song ends (no-loop build only).

## Operation
- ROM entry format is `{degree[1:0], key[6:0], beats[3:0]}`. Contents:
  - 0: 10/C/1
  - 1: 10/C/1
  - 2: 10/G/1
  - 3: 10/G/1
  - 4: 10/A/1
  - 5: 10/A/1
  - 6: 10/G/2
  - 7: 11/C/2
  - Entries 8..15: silent, 1 beat.
- States: IDLE, NOTE, GAP, LIVE. LIVE saves the state it suspended, `resume_state`.
- IDLE: outputs silent. `start` → NOTE, with `note_idx`=0, beat counter loaded.
- NOTE: outputs the ROM entry at `note_idx`. Lasts exactly beats×`BEAT_CYCLES` cycles, then → GAP.
- GAP: outputs silent for `GAP_CYCLES` cycles. At the end of GAP:
  - If `note_idx`<`SONG_LEN`−1: increment `note_idx`, → NOTE.
  - Otherwise: end-of-song handling (see Configuration).
- LIVE entry: `kb_valid`=1 with `kb_key`≠0 and `kb_degree`≠00, in any state.
  - Latch `kb_degree` and `kb_key`, load the hold counter with `LIVE_CYCLES`.
  - Save `resume_state` only if not already in LIVE.
  - All playback counters and `note_idx` are frozen.
- In LIVE, a new valid keystroke replaces the latched note and reloads the hold counter.
- LIVE exit: when the hold expires, return to `resume_state` with the frozen counters intact.
- `kb_valid` with a zero key or zero degree is ignored.
- `stop` in any state → IDLE. Clears live hold and `note_idx`; outputs silent.
- `start` while in NOTE or GAP restarts from entry 0.
- `start` during LIVE sets `resume_state`=NOTE, `note_idx`=0, counters reloaded. The live note continues.

Priority for simultaneous events: `rst` > `stop` > `kb_valid` > `start` > internal counter expiry. Example: with `kb_valid` and `start` in the same IDLE cycle, the bench sees LIVE with `resume_state`=NOTE, idx 0.

## Timing
- All outputs are registered. Reset values: `degree`=00, `key`=0, `playing`=0, `live`=0, `note_idx`=0, `done`=0; state IDLE.
- Latency: any input sampled at edge t is reflected on outputs after edge t (one cycle).
- `start` at edge t: ROM entry 0 is on the outputs from t+1 for beats×`BEAT_CYCLES` cycles.
- Song duration: Σbeats×`BEAT_CYCLES` + `SONG_LEN`×`GAP_CYCLES` cycles from the first note cycle to the end of the last gap.
- `done` asserts in the cycle after the last GAP cycle, for exactly one cycle.
- Counters are 32-bit. Beat and hold counters count down and compare to 1; no wrap is allowed.
- `rst` asserted mid-note: silent and IDLE on the next cycle.

## Configuration
- `MELODY_LOOP_EN` defined: after the final GAP, `note_idx` wraps to 0 and the block → NOTE seamlessly. `done` is tied 0.
- `MELODY_LOOP_EN` undefined: after the final GAP, → IDLE and pulse `done`.

## Test plan
All scenarios use `BEAT_CYCLES`=4, `GAP_CYCLES`=2, `LIVE_CYCLES`=3, `SONG_LEN`=8.
- Reset then idle: all outputs 0 for 20 cycles. `kb_valid` with `kb_key`=0 → stays IDLE.
- Single `start` (no loop): `key`=0000001/`degree`=10 for 4 cycles, silent 2, …
  - Entry 7 shows `degree`=11/`key`=0000001 for 8 cycles.
  - `done` pulses exactly 56 cycles after the first note cycle; then IDLE.
- Live preempt at cycle 2 of entry 2 (G) with `kb_key`=0000100, `kb_degree`=01:
  - E/low for 3 cycles, `live`=1, `note_idx` held at 2.
  - Then G resumes for the remaining 2 cycles.
- Retrigger: second `kb_valid` 2 cycles into LIVE → hold extends to 3 cycles after the second press, showing the new note.
- Simultaneous `stop`+`kb_valid` during NOTE → IDLE, silent, `live`=0. Simultaneous `start`+`stop` → stays IDLE.
- Loop build (`MELODY_LOOP_EN`): after entry 7's gap, `note_idx`=0 and C/mid appears with no idle cycle; `done` never asserts across 3 loops.

Source files
------------

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - melody ROM playback with live keystroke preemption
// Optional feature macro: MELODY_LOOP_EN (loop the song instead of stopping with done).
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000,
    parameter int unsigned LIVE_CYCLES = 50000000,
    parameter int unsigned SONG_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       kb_valid,
    input  logic [1:0] kb_degree,
    input  logic [6:0] kb_key,
    output logic [1:0] degree,
    output logic [6:0] key,
    output logic       playing,
    output logic       live,
    output logic [3:0] note_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2,
        S_LIVE = 2'd3
    } state_t;

    localparam logic [31:0] BEAT_C   = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_C    = 32'(GAP_CYCLES);
    localparam logic [31:0] LIVE_C   = 32'(LIVE_CYCLES);
    localparam logic [3:0]  LAST_IDX = 4'(SONG_LEN - 1);

    // Entry format {degree[1:0], key[6:0], beats[3:0]}
    function automatic logic [12:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: rom_entry = {2'b10, 7'b0000001, 4'd1};
            4'd2, 4'd3: rom_entry = {2'b10, 7'b0010000, 4'd1};
            4'd4, 4'd5: rom_entry = {2'b10, 7'b0100000, 4'd1};
            4'd6:       rom_entry = {2'b10, 7'b0010000, 4'd2};
            4'd7:       rom_entry = {2'b11, 7'b0000001, 4'd2};
            default:    rom_entry = {2'b00, 7'b0000000, 4'd1};
        endcase
    endfunction

    function automatic logic [31:0] note_len(input logic [3:0] idx);
        logic [12:0] e;
        e        = rom_entry(idx);
        note_len = {28'd0, e[3:0]} * BEAT_C;
    endfunction

    state_t      state_q, state_d, resume_q, resume_d, play;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d, hold_q, hold_d;
    logic [1:0]  ldeg_q, ldeg_d, degree_q, degree_d;
    logic [6:0]  lkey_q, lkey_d, key_q, key_d;
    logic        playing_q, playing_d, live_q, live_d, done_q, done_d;
    logic        kb_fire;
    logic [12:0] cur_entry;

    assign kb_fire = kb_valid && (kb_key != 7'd0) && (kb_degree != 2'd0);

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        ldeg_d   = ldeg_q;
        lkey_d   = lkey_q;
        done_d   = 1'b0;
        play     = (state_q == S_LIVE) ? resume_q : state_q;

        if (stop) begin
            state_d  = S_IDLE;
            resume_d = S_IDLE;
            idx_d    = 4'd0;
            cnt_d    = 32'd0;
            hold_d   = 32'd0;
        end else begin
            if (start) begin
                play  = S_NOTE;
                idx_d = 4'd0;
                cnt_d = note_len(4'd0);
            end else if (state_q != S_LIVE) begin
                if (kb_fire) begin
                    // The cycle that carried the keystroke still counts as played time;
                    // an expiry in that same cycle is deferred until after LIVE.
                    if ((state_q != S_IDLE) && (cnt_q != 32'd1))
                        cnt_d = cnt_q - 32'd1;
                end else begin
                    case (state_q)
                        S_NOTE: begin
                            if (cnt_q == 32'd1) begin
                                play  = S_GAP;
                                cnt_d = GAP_C;
                            end else begin
                                cnt_d = cnt_q - 32'd1;
                            end
                        end
                        S_GAP: begin
                            if (cnt_q == 32'd1) begin
                                if (idx_q < LAST_IDX) begin
                                    idx_d = idx_q + 4'd1;
                                    play  = S_NOTE;
                                    cnt_d = note_len(idx_q + 4'd1);
                                end else begin
`ifdef MELODY_LOOP_EN
                                    idx_d = 4'd0;
                                    play  = S_NOTE;
                                    cnt_d = note_len(4'd0);
`else
                                    play   = S_IDLE;
                                    done_d = 1'b1;
`endif
                                end
                            end else begin
                                cnt_d = cnt_q - 32'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (kb_fire) begin
                state_d  = S_LIVE;
                resume_d = play;
                ldeg_d   = kb_degree;
                lkey_d   = kb_key;
                hold_d   = LIVE_C;
            end else if (state_q == S_LIVE) begin
                resume_d = play;
                if (hold_q == 32'd1) begin
                    state_d = play;
                    hold_d  = 32'd0;
                end else begin
                    hold_d = hold_q - 32'd1;
                end
            end else begin
                state_d = play;
            end
        end

        cur_entry = rom_entry(idx_d);
        degree_d  = 2'd0;
        key_d     = 7'd0;
        case (state_d)
            S_NOTE: begin
                degree_d = cur_entry[12:11];
                key_d    = cur_entry[10:4];
            end
            S_LIVE: begin
                degree_d = ldeg_d;
                key_d    = lkey_d;
            end
            default: ;
        endcase
        playing_d = (state_d == S_NOTE) || (state_d == S_GAP) ||
                    ((state_d == S_LIVE) && (resume_d != S_IDLE));
        live_d    = (state_d == S_LIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            resume_q  <= S_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 32'd0;
            hold_q    <= 32'd0;
            ldeg_q    <= 2'd0;
            lkey_q    <= 7'd0;
            degree_q  <= 2'd0;
            key_q     <= 7'd0;
            playing_q <= 1'b0;
            live_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            ldeg_q    <= ldeg_d;
            lkey_q    <= lkey_d;
            degree_q  <= degree_d;
            key_q     <= key_d;
            playing_q <= playing_d;
            live_q    <= live_d;
            done_q    <= done_d;
        end
    end

    assign degree   = degree_q;
    assign key      = key_q;
    assign playing  = playing_q;
    assign live     = live_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule
